cordic_rotate: RTL and testbench

CORDIC_ROTATE -- requirements
Module: cordic_rotate

---
 rtl/cordic_rotate.sv | 144 ++++++++++++++
 tb/tb_cordic_rotate.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotate.sv
// Rotation-mode CORDIC: (magnitude, angle) in, (I, Q) out, AXI-Stream both sides.
// Define CORDIC_ROTATE_ROUND_EN to round outputs half away from zero (default truncates).
module cordic_rotate #(
    parameter int C_S00_AXIS_TDATA_WIDTH  = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH  = 32,
    parameter int C_NUM_CORDIC_ITERATIONS = 16,
    parameter int C_CORDIC_FRAC_WIDTH     = 16,
    parameter int C_CORDIC_GAIN           = 39796
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb
);

    localparam int N = C_NUM_CORDIC_ITERATIONS;
    localparam int W = 34;
    localparam int F = C_CORDIC_FRAC_WIDTH;
    localparam logic [15:0] GAIN = 16'(C_CORDIC_GAIN);

    typedef logic signed [W-1:0] word_t;

    localparam word_t ATAN [0:15] = '{
        34'sd8192, 34'sd4836, 34'sd2555, 34'sd1297,
        34'sd651,  34'sd326,  34'sd163,  34'sd81,
        34'sd41,   34'sd20,   34'sd10,   34'sd5,
        34'sd3,    34'sd1,    34'sd1,    34'sd0
    };

    if (C_CORDIC_FRAC_WIDTH != 16) begin : g_bad_frac
        $fatal(1, "cordic_rotate: C_CORDIC_FRAC_WIDTH must be 16");
    end
    if (N < 1 || N > 16) begin : g_bad_iter
        $fatal(1, "cordic_rotate: C_NUM_CORDIC_ITERATIONS must be 1..16");
    end
    if (C_S00_AXIS_TDATA_WIDTH != 32 || C_M00_AXIS_TDATA_WIDTH != 32) begin : g_bad_w
        $fatal(1, "cordic_rotate: stream widths must be 32");
    end

    word_t x_q    [0:N];
    word_t y_q    [0:N];
    word_t z_q    [0:N];
    logic  vld_q  [0:N];
    logic  last_q [0:N];

    word_t x_d [1:N];
    word_t y_d [1:N];
    word_t z_d [1:N];

    logic        en;
    logic        flip;
    logic [15:0] mag;
    logic [15:0] ang;
    logic [15:0] ang_rot;
    logic [31:0] prod;
    word_t       x0;
    word_t       z0;
    logic        unused_tstrb;

    assign unused_tstrb = ^s00_axis_tstrb;

    assign en              = m00_axis_tready | ~m00_axis_tvalid;
    assign s00_axis_tready = en;

    // Quadrants 1 and 2 are folded by a 180-degree pre-rotation: negate x, shift z by pi.
    assign mag     = s00_axis_tdata[15:0];
    assign ang     = s00_axis_tdata[31:16];
    assign flip    = ang[15] ^ ang[14];
    assign ang_rot = flip ? (ang ^ 16'h8000) : ang;
    assign prod    = 32'(mag) * 32'(GAIN);
    assign x0      = flip ? -word_t'({2'b00, prod}) : word_t'({2'b00, prod});
    assign z0      = word_t'($signed(ang_rot));

    function automatic word_t shr_rtz(input word_t v, input int s);
        shr_rtz = v[W-1] ? -((-v) >>> s) : (v >>> s);
    endfunction

    function automatic logic [15:0] to_out(input word_t v);
        logic [W-1:0] a;
        logic [W-1:0] q;
        a = v[W-1] ? W'(-v) : W'(v);
`ifdef CORDIC_ROTATE_ROUND_EN
        q = (a + W'(32768)) >> F;
`else
        q = a >> F;
`endif
        if (q > W'(32767)) q = W'(32767);
        to_out = v[W-1] ? 16'(-q) : q[15:0];
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (!z_q[i][W-1]) begin
                x_d[i+1] = x_q[i] - shr_rtz(y_q[i], i);
                y_d[i+1] = y_q[i] + shr_rtz(x_q[i], i);
                z_d[i+1] = z_q[i] - ATAN[i];
            end else begin
                x_d[i+1] = x_q[i] + shr_rtz(y_q[i], i);
                y_d[i+1] = y_q[i] - shr_rtz(x_q[i], i);
                z_d[i+1] = z_q[i] + ATAN[i];
            end
        end
    end

    // One global enable: the whole pipe freezes while the output is stalled.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            for (int i = 0; i <= N; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                z_q[i]    <= '0;
                vld_q[i]  <= 1'b0;
                last_q[i] <= 1'b0;
            end
        end else if (en) begin
            x_q[0]    <= x0;
            y_q[0]    <= '0;
            z_q[0]    <= z0;
            vld_q[0]  <= s00_axis_tvalid;
            last_q[0] <= s00_axis_tvalid & s00_axis_tlast;
            for (int i = 1; i <= N; i++) begin
                x_q[i]    <= x_d[i];
                y_q[i]    <= y_d[i];
                z_q[i]    <= z_d[i];
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    assign m00_axis_tvalid = vld_q[N];
    assign m00_axis_tlast  = last_q[N];
    assign m00_axis_tdata  = {to_out(y_q[N]), to_out(x_q[N])};
    assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_cordic_rotate.sv
// Bench for cordic_rotate: integer CORDIC reference model, scoreboard, stall and reset checks.
module tb_cordic_rotate;

    localparam int N = 16;
    localparam int ATAN [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                                 41, 20, 10, 5, 3, 1, 1, 0};
`ifdef CORDIC_ROTATE_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        s00_axis_aclk    = 1'b0;
    logic        s00_axis_aresetn = 1'b0;
    logic        s00_axis_tvalid  = 1'b0;
    logic        s00_axis_tlast   = 1'b0;
    logic        s00_axis_tready;
    logic [31:0] s00_axis_tdata   = '0;
    logic [3:0]  s00_axis_tstrb   = 4'hf;
    logic        m00_axis_tready  = 1'b1;
    logic        m00_axis_tvalid;
    logic        m00_axis_tlast;
    logic [31:0] m00_axis_tdata;
    logic [3:0]  m00_axis_tstrb;

    cordic_rotate dut (
        .s00_axis_aclk    (s00_axis_aclk),
        .s00_axis_aresetn (s00_axis_aresetn),
        .s00_axis_tvalid  (s00_axis_tvalid),
        .s00_axis_tlast   (s00_axis_tlast),
        .s00_axis_tready  (s00_axis_tready),
        .s00_axis_tdata   (s00_axis_tdata),
        .s00_axis_tstrb   (s00_axis_tstrb),
        .m00_axis_tready  (m00_axis_tready),
        .m00_axis_tvalid  (m00_axis_tvalid),
        .m00_axis_tlast   (m00_axis_tlast),
        .m00_axis_tdata   (m00_axis_tdata),
        .m00_axis_tstrb   (m00_axis_tstrb)
    );

    always #5 s00_axis_aclk = ~s00_axis_aclk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        bit          lit;
        int          li, lq, ti, tq;
        int          acc;
        bit          lat;
    } ent_t;

    ent_t sb[$];

    int nvec = 0, nfail = 0, cnt_out = 0, cyc = 0;
    int tmo = 0, tmo_seen = 0;
    int chk_exp = 0;
    bit chk_go = 0, chk_seen = 0;
    bit rnd_ready = 0;
    bit d_lit = 0;
    int d_li = 0, d_lq = 0, d_ti = 0, d_tq = 0;
    bit stall_p = 0;
    logic [31:0] p_data = '0;
    logic        p_last = 1'b0;

    function automatic longint rtz(input longint v, input int s);
        return v / (longint'(1) << s);
    endfunction

    function automatic logic [15:0] sat(input longint v);
        longint a, q;
        a = (v < 0) ? -v : v;
        q = RND ? (a + 32768) / 65536 : a / 65536;
        if (q > 32767) q = 32767;
        return 16'((v < 0) ? -q : q);
    endfunction

    function automatic logic [31:0] model(input int mag, input int ang);
        longint x, y, z, dx, dy;
        int za;
        bit flip;
        flip = (ang / 16384 == 1) || (ang / 16384 == 2);
        za = flip ? (ang + 32768) % 65536 : ang;
        z = (za >= 32768) ? za - 65536 : za;
        x = longint'(mag) * 39796;
        if (flip) x = -x;
        y = 0;
        for (int i = 0; i < N; i++) begin
            dx = rtz(y, i);
            dy = rtz(x, i);
            if (z >= 0) begin
                x = x - dx; y = y + dy; z = z - ATAN[i];
            end else begin
                x = x + dx; y = y - dy; z = z + ATAN[i];
            end
        end
        return {sat(y), sat(x)};
    endfunction

    always @(posedge s00_axis_aclk) cyc++;

    always @(posedge s00_axis_aclk) begin
        #1;
        m00_axis_tready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    always @(negedge s00_axis_aclk) begin
        ent_t e;
        int gi, gq;
        if (!s00_axis_aresetn) begin
            nvec++;
            if (m00_axis_tvalid !== 1'b0 || m00_axis_tlast !== 1'b0 ||
                m00_axis_tdata !== 32'h0 || s00_axis_tready !== 1'b1) begin
                nfail++;
                $display("FAIL reset_state: tvalid=%b tlast=%b tdata=%h s_tready=%b, required 0 0 00000000 1",
                         m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata, s00_axis_tready);
            end
            sb.delete();
            stall_p = 0;
        end else begin
            if (stall_p) begin
                nvec++;
                if (m00_axis_tvalid !== 1'b1 || m00_axis_tdata !== p_data || m00_axis_tlast !== p_last) begin
                    nfail++;
                    $display("FAIL stall_hold: tvalid=%b tdata=%h tlast=%b, required 1 %h %b",
                             m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast, p_data, p_last);
                end
            end
            if (m00_axis_tvalid && m00_axis_tready) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_beat: tdata=%h tlast=%b, required no output",
                             m00_axis_tdata, m00_axis_tlast);
                end else begin
                    e = sb.pop_front();
                    cnt_out++;
                    nvec++;
                    if (m00_axis_tdata !== e.data || m00_axis_tlast !== e.last || m00_axis_tstrb !== 4'hf) begin
                        nfail++;
                        $display("FAIL beat_data: tdata=%h tlast=%b tstrb=%h, required %h %b f",
                                 m00_axis_tdata, m00_axis_tlast, m00_axis_tstrb, e.data, e.last);
                    end
                    if (e.lit) begin
                        gi = int'($signed(m00_axis_tdata[15:0]));
                        gq = int'($signed(m00_axis_tdata[31:16]));
                        nvec++;
                        if (gi > e.li + e.ti || gi < e.li - e.ti || gq > e.lq + e.tq || gq < e.lq - e.tq) begin
                            nfail++;
                            $display("FAIL literal_iq: I=%0d Q=%0d, required I=%0d+/-%0d Q=%0d+/-%0d",
                                     gi, gq, e.li, e.ti, e.lq, e.tq);
                        end
                    end
                    if (e.lat) begin
                        nvec++;
                        if (cyc - e.acc != N + 1) begin
                            nfail++;
                            $display("FAIL latency: %0d cycles, required %0d", cyc - e.acc, N + 1);
                        end
                    end
                end
            end
            if (s00_axis_tvalid && s00_axis_tready) begin
                e.data = model(int'(s00_axis_tdata[15:0]), int'(s00_axis_tdata[31:16]));
                e.last = s00_axis_tlast;
                e.lit  = d_lit;
                e.li   = d_li;
                e.lq   = d_lq;
                e.ti   = d_ti;
                e.tq   = d_tq;
                e.acc  = cyc;
                e.lat  = !rnd_ready;
                sb.push_back(e);
            end
            stall_p = m00_axis_tvalid && !m00_axis_tready;
            p_data  = m00_axis_tdata;
            p_last  = m00_axis_tlast;
        end
        if (chk_go != chk_seen) begin
            chk_seen = chk_go;
            nvec++;
            if (cnt_out != chk_exp || sb.size() != 0) begin
                nfail++;
                $display("FAIL beat_count: got %0d outputs (%0d pending), required %0d (0 pending)",
                         cnt_out, sb.size(), chk_exp);
            end
        end
        if (tmo != tmo_seen) begin
            tmo_seen = tmo;
            nvec++;
            nfail++;
            $display("FAIL timeout: handshake or drain bound expired (%0d), required none", tmo);
        end
    end

    task automatic send(input int mag, input int ang, input bit last);
        bit ok;
        s00_axis_tdata  = {16'(ang), 16'(mag)};
        s00_axis_tlast  = last;
        s00_axis_tvalid = 1'b1;
        ok = 0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge s00_axis_aclk);
            ok = s00_axis_tready;
        end
        if (!ok) tmo++;
        @(posedge s00_axis_aclk);
        #1;
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
        d_lit           = 1'b0;
    endtask

    task automatic send_lit(input int mag, input int ang, input int li, input int lq,
                            input int ti, input int tq);
        d_lit = 1'b1;
        d_li = li; d_lq = lq; d_ti = ti; d_tq = tq;
        send(mag, ang, 1'b0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 3000) begin
            @(posedge s00_axis_aclk);
            k++;
        end
        if (sb.size() != 0) tmo++;
        repeat (3) @(posedge s00_axis_aclk);
        #1;
    endtask

    task automatic check_count(input int exp_cnt);
        chk_exp = exp_cnt;
        chk_go  = ~chk_go;
        @(negedge s00_axis_aclk);
        @(posedge s00_axis_aclk);
        #1;
    endtask

    int base;
    int edge_ang [6] = '{0, 16384, 32768, 49152, 16383, 65535};

    initial begin
        repeat (3) @(posedge s00_axis_aclk);
        #1;
        s00_axis_aresetn = 1'b1;
        @(posedge s00_axis_aclk);
        #1;

        send_lit(10000, 0,     10000,  0,      2, 2);
        send_lit(10000, 16384, 0,      10000,  2, 2);
        send_lit(10000, 32768, -10000, 0,      2, 2);
        send_lit(20000, 8192,  14142,  14142,  3, 3);
        send_lit(20000, 57344, 14142,  -14142, 3, 3);
        send_lit(65535, 0,     32767,  0,      0, 2);
        send_lit(65535, 32768, -32767, 0,      0, 2);
        send_lit(3,     5461,  RND ? 3 : 2, 1, 0, 1);
        drain();
        check_count(8);

        rnd_ready = 1;
        base = cnt_out;
        for (int k = 1; k <= 40; k++)
            send($urandom_range(0, 65535), $urandom_range(0, 65535), k == 40);
        drain();
        check_count(base + 40);

        base = cnt_out;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge s00_axis_aclk);
                #1;
            end
            if ($urandom_range(0, 4) == 0)
                send($urandom_range(0, 65535), edge_ang[$urandom_range(0, 5)], k == 299);
            else
                send($urandom_range(0, 65535), $urandom_range(0, 65535), k == 299);
        end
        drain();
        check_count(base + 300);
        rnd_ready = 0;
        repeat (2) @(posedge s00_axis_aclk);
        #1;

        for (int k = 0; k < 25; k++)
            send($urandom_range(0, 65535), $urandom_range(0, 65535), 1'b0);
        #2;
        s00_axis_aresetn = 1'b0;
        s00_axis_tvalid  = 1'b1;
        s00_axis_tdata   = 32'h4000_1234;
        repeat (3) @(posedge s00_axis_aclk);
        #1;
        s00_axis_aresetn = 1'b1;
        s00_axis_tvalid  = 1'b0;
        base = cnt_out;
        repeat (2) @(posedge s00_axis_aclk);
        #1;
        send(12345, 40000, 1'b1);
        drain();
        check_count(base + 1);

        repeat (2) @(negedge s00_axis_aclk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
